// File: rtl/div_pkg.sv
// Shared constants and types for the divide issue stage and its datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  // The divider raises resultReady at this count; it raises resetCounter one later.
  localparam logic [CNT_W-1:0] DONE_COUNT = 6'd32;
  localparam logic [CNT_W-1:0] OVER_COUNT = 6'd33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2
  } state_t;

  // Magnitude of a two's complement value. 0x80000000 maps to itself, which is
  // still the correct magnitude when read as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/div_counter.sv
// Iteration counter that sequences the divider; clear wins over enable.
// Latency: count updates on the edge after en/clr are sampled.
// Backpressure: none; the sequencer FSM decides when to count.
//
// Ports:
//   i_clock   - clock
//   i_reset_n - asynchronous active-low reset, count -> 0
//   i_en      - increment by one this cycle
//   i_clr     - synchronous clear to 0 (priority over i_en)
//   o_count   - current count
module div_counter
  import div_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/divider.sv
// Iterative signed restoring divider, one quotient bit per count value.
// Latency: count 0 loads operands; quotient valid combinationally while count==32.
// Backpressure: none; the caller owns count and must hold operands stable at count 0.
//
// Ports:
//   clock         - clock
//   data_operandA - dividend (signed)
//   data_operandB - divisor (signed, non-zero)
//   count         - iteration index from the sequencer
//   result        - quotient, truncated toward zero, valid with resultReady
//   resultReady   - count == 32
//   resetCounter  - count == 33 (count overrun indication)
module divider
  import div_pkg::*;
(
  input  logic             clock,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] result,
  output logic             resultReady,
  output logic             resetCounter
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  always_comb begin
    w_shift   = {r_rem, r_quo[WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, r_dvs});
    w_rem_nxt = w_ge ? (w_shift[WIDTH-1:0] - r_dvs) : w_shift[WIDTH-1:0];
    w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
  end

  // Steps 1..31 are registered; the 32nd step is taken combinationally in the
  // count==32 cycle so the result is ready on that cycle's closing edge.
  always_ff @(posedge clock) begin
    if (count == '0) begin
      r_quo <= abs_val(data_operandA);
      r_dvs <= abs_val(data_operandB);
      r_rem <= '0;
      r_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
    end else if (count < DONE_COUNT) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
    end
  end

  assign result       = r_neg ? (~w_quo_nxt + WIDTH'(1)) : w_quo_nxt;
  assign resultReady  = (count == DONE_COUNT);
  assign resetCounter = (count == OVER_COUNT);

endmodule

// File: rtl/div_sequencer.sv
// Divide issue stage: latches a request, sequences the divider, returns a registered result.
// Latency: 33 edges from request edge to RDY cycle; 1 edge for divide-by-zero.
// Backpressure: busy stalls execute; requests seen outside IDLE are dropped, not queued.
//
// Ports:
//   clock          - clock, all state on rising edge
//   reset_n        - asynchronous active-low reset; discards any in-flight divide
//   ctrl_DIV       - one-cycle request pulse, sampled only in IDLE
//   data_operandA  - dividend (signed)
//   data_operandB  - divisor (signed)
//   data_result    - quotient, held until the next completion
//   data_exception - high with data_resultRDY when the divisor was zero
//   data_resultRDY - one-cycle completion pulse
//   busy           - high in RUN and ZERO
module div_sequencer
  import div_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;
  logic             r_rdy;

  logic             w_latch;
  logic             w_cnt_en;
  logic             w_cnt_clr;
  logic [WIDTH-1:0] w_result_nxt;
  logic             w_exception_nxt;
  logic             w_rdy_nxt;

  logic [CNT_W-1:0] w_count;
  logic [WIDTH-1:0] w_div_result;
  logic             w_div_ready;
  logic             w_reset_counter;

  div_counter u_counter (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_en      (w_cnt_en),
    // resetCounter can only fire if count overruns 32, which the FSM never
    // allows; folding it into the clear keeps the counter bounded regardless.
    .i_clr     (w_cnt_clr | w_reset_counter),
    .o_count   (w_count)
  );

  // The divider only ever sees the latched operands, so the execute stage may
  // change its operand buses freely while the divide is running.
  divider u_divider (
    .clock         (clock),
    .data_operandA (r_opa),
    .data_operandB (r_opb),
    .count         (w_count),
    .result        (w_div_result),
    .resultReady   (w_div_ready),
    .resetCounter  (w_reset_counter)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_latch         = 1'b0;
    w_cnt_en        = 1'b0;
    w_cnt_clr       = 1'b0;
    w_result_nxt    = r_result;
    w_exception_nxt = 1'b0;
    w_rdy_nxt       = 1'b0;

    case (r_state)
      IDLE: begin
        // Holding count at 0 means the first RUN cycle is the divider's load cycle.
        w_cnt_clr = 1'b1;
        if (ctrl_DIV) begin
          if (data_operandB != '0) begin
            w_latch     = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = ZERO;
          end
        end
      end

      RUN: begin
        w_cnt_en = 1'b1;
        if (w_div_ready) begin
          w_cnt_clr    = 1'b1;
          w_result_nxt = w_div_result;
          w_rdy_nxt    = 1'b1;
          w_state_nxt  = IDLE;
        end
      end

      ZERO: begin
        w_cnt_clr       = 1'b1;
        w_result_nxt    = '0;
        w_exception_nxt = 1'b1;
        w_rdy_nxt       = 1'b1;
        w_state_nxt     = IDLE;
      end

      default: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_opa <= '0;
      r_opb <= '0;
    end else if (w_latch) begin
      r_opa <= data_operandA;
      r_opb <= data_operandB;
    end
  end

  // RDY and exception default low every cycle, so each completion gives a
  // single-cycle pulse; the quotient itself is held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_result    <= '0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_result    <= w_result_nxt;
      r_exception <= w_exception_nxt;
      r_rdy       <= w_rdy_nxt;
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = r_rdy;
  assign busy           = (r_state == RUN) || (r_state == ZERO);

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed cases from the plan plus randomized divides.
// Latency: expected 33 edges (normal) / 1 edge (zero divisor) request-to-RDY.
// Backpressure: requests injected while busy must be dropped.
module tb_div_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  div_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed division truncating toward zero, low 32 bits kept.
  function automatic logic [31:0] ref_quot(input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    logic [63:0] t;
    if (b == 32'd0) return 32'd0;
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    t  = q;
    return t[31:0];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a request and clock it in; returns just after the request edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    step();
    ctrl_DIV = 1'b0;
  endtask

  // Wait for RDY while scrambling the operand buses; optionally inject a
  // 9/3 request at edge offset inject_at. Returns in the RDY cycle.
  task automatic wait_done(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int inject_at);
    int n;
    int nb;
    int lat;
    n   = 0;
    nb  = 0;
    lat = (b == 32'd0) ? 1 : 33;
    while (!data_resultRDY && n < 100) begin
      if (busy) nb++;
      if (n == inject_at) begin
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd3;
      end else begin
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
      end
      step();
      n++;
    end
    ctrl_DIV = 1'b0;
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_cycles"}, nb, lat);
    check({tag, "_result"}, data_result, ref_quot(a, b));
    check({tag, "_exception"}, {31'd0, data_exception}, {31'd0, (b == 32'd0)});
    check({tag, "_busy_in_rdy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic after_rdy(input string tag, input logic [31:0] exp_result);
    step();
    check({tag, "_rdy_drop"}, {31'd0, data_resultRDY}, 32'd0);
    check({tag, "_exc_drop"}, {31'd0, data_exception}, 32'd0);
    check({tag, "_held"}, data_result, exp_result);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          nrdy;
    int          nbusy;

    reset_n       = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    #1 reset_n = 1'b0;
    #2;
    check("reset_result", data_result, 32'd0);
    check("reset_exception", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    #10 reset_n = 1'b1;
    step();

    // Basic signed cases.
    start_op(32'd100, 32'd7);
    wait_done("p100_p7", 32'd100, 32'd7, -1);
    check("p100_p7_const", data_result, 32'h0000000E);
    after_rdy("p100_p7", 32'h0000000E);

    start_op(32'hFFFFFF9C, 32'd7);
    wait_done("m100_p7", 32'hFFFFFF9C, 32'd7, -1);
    check("m100_p7_const", data_result, 32'hFFFFFFF2);
    after_rdy("m100_p7", 32'hFFFFFFF2);

    start_op(32'hFFFFFF9C, 32'hFFFFFFF9);
    wait_done("m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, -1);
    check("m100_m7_const", data_result, 32'd14);
    after_rdy("m100_m7", 32'd14);

    // Divide by zero: one busy cycle, exception with RDY.
    start_op(32'd7, 32'd0);
    wait_done("div0", 32'd7, 32'd0, -1);
    check("div0_exc_const", {31'd0, data_exception}, 32'd1);
    after_rdy("div0", 32'd0);

    // Request during RUN is dropped; then back-to-back issue in the RDY cycle.
    start_op(32'd100, 32'd7);
    wait_done("ignored_req", 32'd100, 32'd7, 5);
    start_op(32'd9, 32'd3);
    wait_done("back2back", 32'd9, 32'd3, -1);
    check("back2back_const", data_result, 32'd3);
    after_rdy("back2back", 32'd3);

    // Asynchronous reset mid-divide at count 10.
    start_op(32'd100, 32'd7);
    repeat (10) step();
    #2 reset_n = 1'b0;
    #1;
    check("midreset_result", data_result, 32'd0);
    check("midreset_exception", {31'd0, data_exception}, 32'd0);
    check("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    repeat (2) step();
    #2 reset_n = 1'b1;
    step();
    nrdy  = 0;
    nbusy = 0;
    repeat (40) begin
      if (data_resultRDY) nrdy++;
      if (busy) nbusy++;
      step();
    end
    check("midreset_no_rdy", nrdy, 0);
    check("midreset_no_busy", nbusy, 0);
    start_op(32'd50, 32'd5);
    wait_done("after_reset", 32'd50, 32'd5, -1);
    check("after_reset_const", data_result, 32'd10);
    after_rdy("after_reset", 32'd10);

    // Operand buses scrambled every RUN cycle inside wait_done.
    start_op(32'd1000, 32'd10);
    wait_done("latched_ops", 32'd1000, 32'd10, -1);
    check("latched_ops_const", data_result, 32'd100);
    after_rdy("latched_ops", 32'd100);

    // Known corner: most negative / -1 wraps to 0x80000000, no exception.
    start_op(32'h80000000, 32'hFFFFFFFF);
    wait_done("min_by_m1", 32'h80000000, 32'hFFFFFFFF, -1);
    check("min_by_m1_const", data_result, 32'h80000000);
    after_rdy("min_by_m1", 32'h80000000);

    // Randomized divides, some back-to-back, some by zero.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      start_op(a, b);
      wait_done($sformatf("rand%0d", i), a, b, ($urandom_range(0, 3) == 0) ? 3 : -1);
      if ($urandom_range(0, 1) == 0) after_rdy($sformatf("rand%0d", i), ref_quot(a, b));
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
